simple_mul: RTL and testbench

//  Iterative shift-add multiplier; the multiply counterpart to the core's iterative divider.

---
 rtl/simple_mul_if.sv | 16 +
 rtl/simple_mul.sv | 125 ++++++++++++
 tb/tb_simple_mul.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/simple_mul_if.sv
// simple_mul_if: start/busy handshake and hi/lo result bus for the iterative multiplier.
interface simple_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sign;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output A, B, sign, start, input busy, done, hi, lo);
  modport slave  (input A, B, sign, start, output busy, done, hi, lo);
endinterface

// File: rtl/simple_mul.sv
// simple_mul: iterative shift-add multiplier, full 2*WIDTH product on hi/lo.
// Retires BITS_PER_CYC multiplier bits per cycle; one op in flight, start restarts.
// Optional: define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
module simple_mul #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  simple_mul_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYC;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if (!((BITS_PER_CYC == 1) || (BITS_PER_CYC == 2) || (BITS_PER_CYC == 4)) ||
      ((WIDTH % BITS_PER_CYC) != 0)) begin : g_bad_cfg
    $error("simple_mul: BITS_PER_CYC must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_partial;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     w_mplier_nxt;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_done;
  logic                 w_last;
  logic                 w_finish;

  // Operand magnitudes; the most negative value maps onto itself, read as unsigned.
  always_comb begin
    w_abs_a = (bus.sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    w_abs_b = (bus.sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // One step: add the multiplicand multiples selected by the low multiplier bits.
  // The multiplicand register is pre-shifted each step instead of tracking a shift amount.
  always_comb begin
    w_partial = '0;
    for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
    w_acc_nxt    = r_acc + w_partial;
    w_mplier_nxt = r_mplier >> BITS_PER_CYC;
  end

  // Last-step detection.
  always_comb begin
`ifdef MUL_EARLY_OUT_EN
    w_last = (r_cnt == CNT_W'(1)) || (w_mplier_nxt == '0);
`else
    w_last = (r_cnt == CNT_W'(1));
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; start always wins, including over the finishing step.
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = RUN;
      RUN: begin
        if (bus.start) begin
          w_state_nxt = RUN;
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on start, accumulate while running, publish the result on finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (bus.start) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_acc    <= '0;
        r_cnt    <= CNT_W'(STEPS);
        r_neg    <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      end else if (r_state == RUN) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << BITS_PER_CYC;
        r_mplier <= w_mplier_nxt;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (w_finish) {r_hi, r_lo} <= r_neg ? -w_acc_nxt : w_acc_nxt;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_simple_mul.sv
// tb_simple_mul: directed vectors against a latency/product model of the multiplier.
module tb_simple_mul;

  localparam int unsigned W   = 32;
  localparam int unsigned BPC = 1;
  localparam int unsigned STEPS = W / BPC;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simple_mul_if #(.WIDTH(W)) u_if ();

  simple_mul #(.WIDTH(W), .BITS_PER_CYC(BPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact product from sign-extended operands, and cycle count to finish.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic int ref_steps(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int hb, n;
    if (!EARLY) return int'(STEPS);
    mag = (s && b[31]) ? -b : b;
    hb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i + 1;
    n = (hb + int'(BPC) - 1) / int'(BPC);
    return (n == 0) ? 1 : n;
  endfunction

  // Model state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (u_if.start) begin
        m_pend <= ref_product(u_if.A, u_if.B, u_if.sign);
        m_left <= ref_steps(u_if.B, u_if.sign);
        m_busy <= 1'b1;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
        m_left <= m_left - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 64'(u_if.busy), 64'(m_busy));
    chk("done", 64'(u_if.done), 64'(m_done));
    chk("prod", {u_if.hi, u_if.lo}, m_prod);
    if (u_if.done === 1'b1) n_done++;
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    u_if.A     = a;
    u_if.B     = b;
    u_if.sign  = s;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (u_if.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    #1;
    if (cyc >= 200) chk("timeout", 64'(cyc), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int base;
    u_if.A = '0; u_if.B = '0; u_if.sign = 1'b0; u_if.start = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_busy", 64'(u_if.busy), 64'd0);
    chk("reset_prod", {u_if.hi, u_if.lo}, 64'd0);
    @(negedge clk);

    // Unsigned all-ones
    base = n_done;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(cyc);
    chk("t1_lat", 64'(cyc), 64'd32);
    chk("t1_prod", {u_if.hi, u_if.lo}, 64'hFFFF_FFFE_0000_0001);
    chk("t1_ndone", 64'(n_done - base), 64'd1);
    @(negedge clk);

    // Signed -3 * 7
    do_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_idle(cyc);
    chk("t2_prod", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);

    // Most negative squared, signed then unsigned
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_idle(cyc);
    chk("t3_signed", {u_if.hi, u_if.lo}, 64'h4000_0000_0000_0000);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_idle(cyc);
    chk("t3_unsigned", {u_if.hi, u_if.lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);

    // Restart at busy cycle 10
    base = n_done;
    do_op(32'd5, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    do_op(32'd9, 32'd9, 1'b0);
    wait_idle(cyc);
    chk("t4_lat", 64'(cyc), EARLY ? 64'd4 : 64'd32);
    chk("t4_prod", {u_if.hi, u_if.lo}, 64'd81);
    chk("t4_ndone", 64'(n_done - base), EARLY ? 64'd2 : 64'd1);

    // Reset mid-op at busy cycle 15
    @(negedge clk);
    do_op(32'd2, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 64'(u_if.busy), 64'd0);
    chk("t5_prod", {u_if.hi, u_if.lo}, 64'd0);
    chk("t5_done", 64'(u_if.done), 64'd0);
    base = n_done;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("t5_ndone", 64'(n_done - base), 64'd0);
    chk("t5_hold", {u_if.hi, u_if.lo}, 64'd0);
    @(negedge clk);

    // Start on the finishing edge: start wins
    do_op(32'd7, 32'd7, 1'b0);
    repeat (31) @(negedge clk);
    base = n_done;
    do_op(32'd3, 32'd4, 1'b0);
    wait_idle(cyc);
    chk("tf_prod", {u_if.hi, u_if.lo}, 64'd12);
    chk("tf_ndone", 64'(n_done - base), 64'd1);
    @(negedge clk);

    // Early-out cases (fixed latency when the feature is off)
    do_op(32'd5, 32'd2, 1'b0);
    wait_idle(cyc);
    chk("t6_lat", 64'(cyc), EARLY ? 64'd2 : 64'd32);
    chk("t6_prod", {u_if.hi, u_if.lo}, 64'd10);
    do_op(32'd5, 32'd0, 1'b0);
    wait_idle(cyc);
    chk("t6_zero_lat", 64'(cyc), EARLY ? 64'd1 : 64'd32);
    chk("t6_zero_prod", {u_if.hi, u_if.lo}, 64'd0);

    // Mixed signs, signed x unsigned interpretation
    do_op(32'h0001_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(cyc);
    chk("t7_prod", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_0000);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
